// File: rtl/blaster_pkg.sv
// Shared constants and FSM state encoding for the dual-channel ADC frame receiver.
package blaster_pkg;

    localparam int ADC_BITS  = 12;
    localparam int QUIET_LEN = 2;
    localparam int DATA_LEN  = 6;
    localparam int CYC_W     = 6;
    localparam int CNT_W     = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_QUIET,
        ST_LEAD,
        ST_DATA,
        ST_TAIL
    } rx_state_e;

endpackage

// File: rtl/ad_lane_shift.sv
// Two-lane MSB-first deserializer with a held output word updated on a load strobe.
module ad_lane_shift
    import blaster_pkg::*;
(
    input  logic                clk,
    input  logic                reset_n,
    input  logic                shift_en,
    input  logic                load,
    input  logic [1:0]          sdata,
    output logic [ADC_BITS-1:0] sample
);

    logic [ADC_BITS-1:0] shift_d, shift_q;
    logic [ADC_BITS-1:0] sample_d, sample_q;

    // Lane 1 lands one bit above lane 0, so each shift consumes one bit pair.
    always_comb begin
        shift_d  = shift_q;
        sample_d = sample_q;
        if (shift_en) begin
            shift_d = {shift_q[ADC_BITS-3:0], sdata};
        end
        if (load) begin
            sample_d = shift_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            shift_q  <= '0;
            sample_q <= '0;
        end else begin
            shift_q  <= shift_d;
            sample_q <= sample_d;
        end
    end

    assign sample = sample_q;

endmodule

// File: rtl/ad_frame_rx.sv
// Frame sequencer for a dual-channel, two-lane serial ADC: drives chip select,
// deserializes both channels and publishes each completed conversion with a strobe.
module ad_frame_rx
    import blaster_pkg::*;
#(
    parameter int FRAME_LEN = 16,
    parameter int LEAD      = 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    output logic                ad_cs,
    input  logic [1:0]          ad_sdata_a,
    input  logic [1:0]          ad_sdata_b,
    output logic [ADC_BITS-1:0] sample_a,
    output logic [ADC_BITS-1:0] sample_b,
    output logic                sample_valid,
    output logic [CNT_W-1:0]    frame_cnt,
    output logic                busy
);

    if (FRAME_LEN < 10 || FRAME_LEN > 64) begin : g_bad_frame_len
        $error("ad_frame_rx: FRAME_LEN must be within 10..64");
    end
    if (LEAD < 0 || LEAD > 2) begin : g_bad_lead
        $error("ad_frame_rx: LEAD must be within 0..2");
    end

    localparam logic [CYC_W-1:0] LEAD_START = CYC_W'(QUIET_LEN);
    localparam logic [CYC_W-1:0] DATA_START = CYC_W'(QUIET_LEN + LEAD);
    localparam logic [CYC_W-1:0] DATA_LAST  = CYC_W'(QUIET_LEN + LEAD + DATA_LEN - 1);
    localparam logic [CYC_W-1:0] FRAME_LAST = CYC_W'(FRAME_LEN - 1);

    rx_state_e          state_d, state_q;
    logic [CYC_W-1:0]   cyc_d, cyc_q;
    logic               ad_cs_d, ad_cs_q;
    logic               busy_d, busy_q;
    logic               data_done_d, data_done_q;
    logic               sample_valid_d, sample_valid_q;
    logic [CNT_W-1:0]   frame_cnt_d, frame_cnt_q;

    // Pin-level outputs are derived from the next state so they line up with it once registered.
    always_comb begin
        state_d        = state_q;
        cyc_d          = cyc_q;
        data_done_d    = 1'b0;
        sample_valid_d = data_done_q;
        frame_cnt_d    = frame_cnt_q;
        if (data_done_q) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
        if (state_q == ST_IDLE) begin
            if (enable) begin
                state_d = ST_QUIET;
                cyc_d   = '0;
            end
        end else begin
            data_done_d = (state_q == ST_DATA) && (cyc_q == DATA_LAST);
            if (cyc_q == FRAME_LAST) begin
                cyc_d   = '0;
                state_d = enable ? ST_QUIET : ST_IDLE;
            end else begin
                cyc_d = cyc_q + 1'b1;
                if (cyc_d < LEAD_START) begin
                    state_d = ST_QUIET;
                end else if (cyc_d < DATA_START) begin
                    state_d = ST_LEAD;
                end else if (cyc_d <= DATA_LAST) begin
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_TAIL;
                end
            end
        end
        ad_cs_d = (state_d == ST_IDLE) || (state_d == ST_QUIET);
        busy_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            cyc_q          <= '0;
            ad_cs_q        <= 1'b1;
            busy_q         <= 1'b0;
            data_done_q    <= 1'b0;
            sample_valid_q <= 1'b0;
            frame_cnt_q    <= '0;
        end else begin
            state_q        <= state_d;
            cyc_q          <= cyc_d;
            ad_cs_q        <= ad_cs_d;
            busy_q         <= busy_d;
            data_done_q    <= data_done_d;
            sample_valid_q <= sample_valid_d;
            frame_cnt_q    <= frame_cnt_d;
        end
    end

    ad_lane_shift u_lane_a (
        .clk      (clk),
        .reset_n  (reset_n),
        .shift_en (state_q == ST_DATA),
        .load     (data_done_q),
        .sdata    (ad_sdata_a),
        .sample   (sample_a)
    );

    ad_lane_shift u_lane_b (
        .clk      (clk),
        .reset_n  (reset_n),
        .shift_en (state_q == ST_DATA),
        .load     (data_done_q),
        .sdata    (ad_sdata_b),
        .sample   (sample_b)
    );

    assign ad_cs        = ad_cs_q;
    assign busy         = busy_q;
    assign sample_valid = sample_valid_q;
    assign frame_cnt    = frame_cnt_q;

endmodule
